// File: rtl/elink_pkg.sv
// elink_pkg: K28.5 idle constants and elaboration-time helpers for the e-link transmit path
package elink_pkg;
  localparam logic [9:0] IDLE_NEG = 10'h0FA;
  localparam logic [9:0] IDLE_POS = 10'h305;
  localparam logic [7:0] IDLE_8B = 8'hBC;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int cw(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction
  function automatic bit cfg_ok(input int dw, input int ow, input int depth, input int pfull);
    bit ow_ok;
    ow_ok = (dw == 10) ? (ow == 1 || ow == 2 || ow == 5 || ow == 10) :
            (dw == 8) ? (ow == 1 || ow == 2 || ow == 4 || ow == 8) : 1'b0;
    return ow_ok && depth >= 4 && (1 << clog2(depth)) == depth && pfull >= 1 && pfull <= depth;
  endfunction
endpackage

// File: rtl/elink_sync_fifo.sv
// elink_sync_fifo: single-clock FWFT FIFO with registered count flags, flush and sticky overflow
module elink_sync_fifo import elink_pkg::*; #(
  parameter int DATA_W = 10,
  parameter int DEPTH = 16,
  parameter int PFULL_TH = 12
) (
  input  logic              clk_40,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              flush,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              pfull,
  output logic              full,
  output logic              empty,
  output logic              ovf
);
  localparam int AW = clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pfull_q, pfull_d, full_q, full_d, empty_q, empty_d, ovf_q, ovf_d, wr;
  always_comb begin
    wr = we & ~full_q & ~flush;
    wp_d = flush ? '0 : wp_q + AW'(wr);
    rp_d = flush ? '0 : rp_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d = ~flush & (ovf_q | (we & full_q));
    pfull_d = cnt_d >= (AW+1)'(PFULL_TH);
    full_d = cnt_d == (AW+1)'(DEPTH);
    empty_d = cnt_d == '0;
  end
  always_ff @(posedge clk_40 or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      pfull_q <= 1'b0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      pfull_q <= pfull_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  always_ff @(posedge clk_40)
    if (wr) mem[wp_q] <= din;
  assign head = mem[rp_q];
  assign pfull = pfull_q;
  assign full = full_q;
  assign empty = empty_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/elink_tx_fifo_ser.sv
// elink_tx_fifo_ser: FIFO-fed gearbox serializer emitting OUT_W bits per cycle with idle comma fill
module elink_tx_fifo_ser import elink_pkg::*; #(
  parameter int DATA_W = 10,
  parameter int OUT_W = 2,
  parameter int DEPTH = 16,
  parameter int PFULL_TH = 12,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_ALT = 1'b1
) (
  input  logic              clk_40,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_we,
  input  logic              fifo_flush,
  input  logic              tx_en,
  output logic              fifo_pfull,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_ovf,
  output logic [OUT_W-1:0]  elink_out,
  output logic [15:0]       word_cnt
);
  localparam int N = DATA_W / OUT_W;
  localparam int CW = cw(N);
  if (!cfg_ok(DATA_W, OUT_W, DEPTH, PFULL_TH)) begin : g_bad_cfg
    $error("elink_tx_fifo_ser: illegal DATA_W/OUT_W/DEPTH/PFULL_TH combination");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sreg_q, sreg_d, head, word, rev;
  logic [OUT_W-1:0] out_q, out_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic disp_q, disp_d, load, pop;
  elink_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PFULL_TH(PFULL_TH)) u_fifo (
    .clk_40(clk_40),
    .rst(rst),
    .din(fifo_din),
    .we(fifo_we),
    .flush(fifo_flush),
    .pop(pop),
    .head(head),
    .pfull(fifo_pfull),
    .full(fifo_full),
    .empty(fifo_empty),
    .ovf(fifo_ovf)
  );
  always_comb begin
    load = cnt_q == CW'(N - 1);
    pop = load & tx_en & ~fifo_empty & ~fifo_flush;
    word = pop ? head : (DATA_W == 10) ? DATA_W'(disp_q ? IDLE_POS : IDLE_NEG) : DATA_W'(IDLE_8B);
    for (int i = 0; i < DATA_W; i++) rev[i] = word[DATA_W-1-i];
    cnt_d = load ? '0 : cnt_q + 1'b1;
    sreg_d = load ? (MSB_FIRST ? word : rev) : sreg_q << OUT_W;
    out_d = sreg_q[DATA_W-1 -: OUT_W];
    disp_d = disp_q ^ (IDLE_ALT & load & ~pop);
    wcnt_d = wcnt_q + 16'(pop);
  end
  always_ff @(posedge clk_40 or posedge rst)
    if (rst) begin
      cnt_q <= CW'(N - 1);
      sreg_q <= '0;
      out_q <= '0;
      wcnt_q <= '0;
      disp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sreg_q <= sreg_d;
      out_q <= out_d;
      wcnt_q <= wcnt_d;
      disp_q <= disp_d;
    end
  assign elink_out = out_q;
  assign word_cnt = wcnt_q;
endmodule

// File: tb/tb_elink_tx_fifo_ser.sv
// tb_elink_tx_fifo_ser: table vectors, corner sequences and randomized traffic against a queue model
module tb_elink_tx_fifo_ser;
  logic clk_40 = 1'b0, rst = 1'b1;
  always #5 clk_40 = ~clk_40;
  logic we = 1'b0, flush = 1'b0, tx_en = 1'b0;
  logic [9:0] din = '0;
  logic pfull, full, empty, ovf;
  logic [1:0] eout;
  logic [15:0] wcnt;
  logic we1 = 1'b0, tx1 = 1'b0;
  logic [7:0] din1 = '0;
  logic pfull1, full1, empty1, ovf1;
  logic [3:0] eout1;
  logic [15:0] wcnt1;
  int checks = 0, errors = 0;

  elink_tx_fifo_ser dut (
    .clk_40(clk_40), .rst(rst), .fifo_din(din), .fifo_we(we), .fifo_flush(flush), .tx_en(tx_en),
    .fifo_pfull(pfull), .fifo_full(full), .fifo_empty(empty), .fifo_ovf(ovf),
    .elink_out(eout), .word_cnt(wcnt)
  );
  elink_tx_fifo_ser #(.DATA_W(8), .OUT_W(4), .DEPTH(4), .PFULL_TH(3), .MSB_FIRST(1'b0)) dut8 (
    .clk_40(clk_40), .rst(rst), .fifo_din(din1), .fifo_we(we1), .fifo_flush(1'b0), .tx_en(tx1),
    .fifo_pfull(pfull1), .fifo_full(full1), .fifo_empty(empty1), .fifo_ovf(ovf1),
    .elink_out(eout1), .word_cnt(wcnt1)
  );

  // Reference: FIFO contents as a queue, expected line slices as a queue filled at each word boundary
  logic [9:0] mq[$];
  logic [1:0] sq[$];
  int ph;
  bit mdisp, movf;
  logic [15:0] mwc;
  logic [1:0] mout;

  task automatic model_reset();
    mq.delete();
    sq.delete();
    ph = 0;
    mdisp = 1'b0;
    movf = 1'b0;
    mwc = '0;
    mout = '0;
  endtask

  task automatic model_edge(input bit w_en, input logic [9:0] d, input bit tx, input bit fl);
    bit ld, pp;
    int sz;
    logic [9:0] w;
    ld = (ph % 5) == 0;
    sz = mq.size();
    pp = ld && tx && sz > 0 && !fl;
    mout = (sq.size() > 0) ? sq.pop_front() : 2'b00;
    if (ld) begin
      w = pp ? mq[0] : (mdisp ? 10'h305 : 10'h0FA);
      if (pp) mwc = mwc + 16'd1;
      else mdisp = !mdisp;
      for (int k = 0; k < 5; k++) sq.push_back(2'((w >> (8 - 2 * k)) & 10'h3));
    end
    if (fl) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (w_en) begin
        if (sz == 16) movf = 1'b1;
        else mq.push_back(d);
      end
    end
    ph++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model_vec();
    return {10'b0, mout, mq.size() >= 12, mq.size() == 16, mq.size() == 0, movf, mwc};
  endfunction

  task automatic step();
    @(posedge clk_40);
    model_edge(we, din, tx_en, flush);
    #1;
    chk($sformatf("model@%0d", ph), {10'b0, eout, pfull, full, empty, ovf, wcnt}, model_vec());
  endtask

  task automatic do_reset();
    @(negedge clk_40);
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset_state", {10'b0, eout, pfull, full, empty, ovf, wcnt}, {10'b0, 2'b00, 4'b0010, 16'h0});
    @(negedge clk_40);
    rst = 1'b0;
  endtask

  typedef struct {
    bit tx;
    int nw;
    logic [9:0] w0, w1, w2;
    logic [9:0] exp_w;
    logic [15:0] exp_wc;
  } row_t;
  row_t tbl[8];

  typedef struct {
    bit w;
    logic [7:0] d;
    logic [3:0] exp;
  } row8_t;
  row8_t tbl8[7];

  logic [9:0] acc;
  logic [15:0] wc0;

  initial begin
    tbl = '{
      '{1'b0, 0, 10'h000, 10'h000, 10'h000, 10'h0FA, 16'd0},
      '{1'b0, 0, 10'h000, 10'h000, 10'h000, 10'h305, 16'd0},
      '{1'b0, 0, 10'h000, 10'h000, 10'h000, 10'h0FA, 16'd0},
      '{1'b1, 3, 10'h3FF, 10'h000, 10'h2AA, 10'h305, 16'd1},
      '{1'b1, 0, 10'h000, 10'h000, 10'h000, 10'h3FF, 16'd2},
      '{1'b1, 0, 10'h000, 10'h000, 10'h000, 10'h000, 16'd3},
      '{1'b1, 0, 10'h000, 10'h000, 10'h000, 10'h2AA, 16'd3},
      '{1'b1, 0, 10'h000, 10'h000, 10'h000, 10'h0FA, 16'd3}
    };
    tbl8 = '{
      '{1'b1, 8'hA5, 4'h0}, '{1'b0, 8'h00, 4'h3}, '{1'b0, 8'h00, 4'hD}, '{1'b0, 8'h00, 4'hA},
      '{1'b0, 8'h00, 4'h5}, '{1'b0, 8'h00, 4'h3}, '{1'b0, 8'h00, 4'hD}
    };
    do_reset();
    // Idle stream with tx_en low, then three back-to-back words
    step();
    chk("first_slice", 32'(eout), 32'h0);
    for (int r = 0; r < 8; r++) begin
      tx_en = tbl[r].tx;
      acc = '0;
      for (int k = 0; k < 5; k++) begin
        we = k < tbl[r].nw;
        din = (k == 0) ? tbl[r].w0 : (k == 1) ? tbl[r].w1 : tbl[r].w2;
        step();
        acc = {acc[7:0], eout};
      end
      we = 1'b0;
      chk($sformatf("tbl%0d_word", r), 32'(acc), 32'(tbl[r].exp_w));
      chk($sformatf("tbl%0d_wcnt", r), 32'(wcnt), 32'(tbl[r].exp_wc));
    end
    // Fill past full: pfull at 12, full at 16, overflow on the 17th
    tx_en = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      we = 1'b1;
      din = 10'((i * 37 + 5) & 10'h3FF);
      step();
      chk($sformatf("fill%0d_flags", i), {29'b0, pfull, full, ovf}, {29'b0, i >= 12, i >= 16, i >= 17});
    end
    we = 1'b0;
    wc0 = wcnt;
    tx_en = 1'b1;
    repeat (16 * 5 + 6) step();
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_wcnt", 32'(wcnt - wc0), 32'd16);
    // Flush with queued words and a same-cycle write
    for (int i = 0; i < 8; i++) begin
      we = 1'b1;
      din = 10'(i * 91 + 3);
      step();
    end
    we = 1'b1;
    flush = 1'b1;
    din = 10'h155;
    step();
    we = 1'b0;
    flush = 1'b0;
    chk("flush_flags", {28'b0, pfull, full, empty, ovf}, {28'b0, 4'b0010});
    repeat (12) step();
    chk("flush_stays_empty", 32'(empty), 32'h1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      we = ($urandom % 10) < 6;
      din = 10'($urandom);
      tx_en = ($urandom % 10) != 0;
      flush = ($urandom % 40) == 0;
      step();
    end
    flush = 1'b0;
    // Reset in the middle of a data word
    we = 1'b1;
    din = 10'h3C3;
    tx_en = 1'b1;
    repeat (7) step();
    we = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {10'b0, eout, pfull, full, empty, ovf, wcnt}, {10'b0, 2'b00, 4'b0010, 16'h0});
    model_reset();
    @(negedge clk_40);
    rst = 1'b0;
    we = 1'b1;
    din = 10'h3FF;
    step();
    we = 1'b0;
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      acc = {acc[7:0], eout};
    end
    chk("post_reset_idle", 32'(acc), 32'h0FA);
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      acc = {acc[7:0], eout};
    end
    chk("post_reset_data", 32'(acc), 32'h3FF);
    // 8-bit raw words, 4-bit slices, LSB first
    tx_en = 1'b0;
    do_reset();
    tx1 = 1'b1;
    for (int r = 0; r < 7; r++) begin
      we1 = tbl8[r].w;
      din1 = tbl8[r].d;
      step();
      chk($sformatf("raw8_slice%0d", r), 32'(eout1), 32'(tbl8[r].exp));
    end
    we1 = 1'b0;
    chk("raw8_wcnt", 32'(wcnt1), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
